// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// small IDLE/RUN/HALTED controller. Instruction memory is external and
// combinational: imem_addr is the PC, imem_instr returns in the same cycle.
module fetch_unit #(
  parameter int                       DATA_WIDTH    = 20,
  parameter int                       ADDRESS_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]    HALT_WORD     = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  output logic [DATA_WIDTH-1:0]    ifid_instr,
  output logic [ADDRESS_WIDTH-1:0] ifid_pc,
  output logic [ADDRESS_WIDTH-1:0] ifid_pc_plus1,
  output logic                     ifid_valid,
  output logic                     halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] pc_inc;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] ipc_q, ipc_d;
  logic [ADDRESS_WIDTH-1:0] ipc1_q, ipc1_d;
  logic                     valid_q, valid_d;

  // Truncating increment: the all-ones address wraps to zero.
  assign pc_inc = pc_q + 1'b1;

  // Next-state and next-register values; redirect beats stall beats fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc1_d  = ipc1_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      instr_d = '0;
      ipc_d   = '0;
      ipc1_d  = '0;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (!stall) begin
      unique case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          state_d = RUN;
        end
        RUN: begin
          instr_d = imem_instr;
          ipc_d   = pc_q;
          ipc1_d  = pc_inc;
          valid_d = 1'b1;
          // A halt word is delivered to decode but the PC parks on it.
          if (imem_instr == HALT_WORD) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_inc;
          end
        end
        HALTED: begin
          valid_d = 1'b0;
        end
        default: begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc1_q  <= ipc1_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ipc_q;
  assign ifid_pc_plus1 = ipc1_q;
  assign ifid_valid    = valid_q;
  assign halted        = (state_q == HALTED);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 20, instruction word width.
REQ-002 Parameter ADDRESS_WIDTH, default 8, PC / instruction-memory address width.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Parameter HALT_WORD, default all-ones (DATA_WIDTH bits), instruction encoding that halts fetch.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  hazard stall from decode; freeze PC and IF/ID register.
REQ-008 redirect  input  1  taken branch/jump; load redirect_pc and flush IF/ID.
REQ-009 redirect_pc  input  ADDRESS_WIDTH  branch/jump target.
REQ-010 imem_addr  output  ADDRESS_WIDTH  address to combinational instruction memory.
REQ-011 imem_instr  input  DATA_WIDTH  instruction returned for imem_addr in the same cycle.
REQ-012 ifid_instr  output  DATA_WIDTH  registered instruction for decode.
REQ-013 ifid_pc  output  ADDRESS_WIDTH  registered PC of ifid_instr.
REQ-014 ifid_pc_plus1  output  ADDRESS_WIDTH  registered ifid_pc+1, modulo 2^ADDRESS_WIDTH.
REQ-015 ifid_valid  output  1  ifid_* holds a real instruction (0 = bubble).
REQ-016 halted  output  1  high while FSM is in HALTED.

Function
REQ-017 imem_addr SHALL equal the PC register combinationally; no other path drives it.
REQ-018 FSM states SHALL be IDLE, RUN, HALTED; IDLE is entered only by reset.
REQ-019 Event priority SHALL be rst > redirect > stall > normal fetch, in every state.
REQ-020 IDLE, no redirect: PC holds, ifid_valid<=0, next state RUN (exactly one bubble after reset).
REQ-021 RUN, normal fetch (no stall, no redirect, imem_instr != HALT_WORD): PC<=PC+1; ifid_instr<=imem_instr; ifid_pc<=PC; ifid_pc_plus1<=PC+1; ifid_valid<=1.
REQ-022 Fetch latency: instruction at address A SHALL appear on ifid_* exactly one cycle after imem_addr==A in an unstalled RUN cycle.
REQ-023 stall without redirect (any state): PC and all ifid_* outputs hold their values; state holds.
REQ-024 redirect (any state, stall ignored): PC<=redirect_pc; ifid_valid<=0; ifid_instr<=0; ifid_pc, ifid_pc_plus1<=0; next state RUN.
REQ-025 RUN, normal fetch with imem_instr==HALT_WORD: IF/ID loads as REQ-021 (halt word valid), PC holds, next state HALTED.
REQ-026 HALTED, no stall, no redirect: PC holds; ifid_valid<=0; state holds.
REQ-027 PC increment SHALL be ADDRESS_WIDTH-bit truncating: 2^ADDRESS_WIDTH-1 wraps to 0; ifid_pc_plus1 wraps likewise.
REQ-028 A stalled HALT_WORD fetch SHALL NOT enter HALTED until the cycle stall drops.
REQ-029 halted SHALL be a decode of the state register only (no combinational input path).

Reset
REQ-030 On rst=1 at a clock edge: PC<=RESET_PC; state<=IDLE; ifid_instr, ifid_pc, ifid_pc_plus1<=0; ifid_valid<=0; halted=0.
REQ-031 rst SHALL override redirect and stall in the same cycle, including mid-stall and in HALTED.
REQ-032 No output SHALL be X after the first reset edge, regardless of imem_instr.

Verification
REQ-033 Reset, then free-run with memory[i]=i: cycle 1 ifid_valid=0; from cycle 2 ifid_pc=0,1,2... with ifid_instr=ifid_pc, ifid_pc_plus1=ifid_pc+1.
REQ-034 Free-run to PC=255, no halt: imem_addr 255 -> 0; IF/ID shows ifid_pc=255, ifid_pc_plus1=0, then ifid_pc=0.
REQ-035 Stall 3 cycles while ifid_pc=5: ifid_pc stays 5, ifid_valid stays 1, imem_addr stays 6; fetch of 6 resumes the cycle after stall drops.
REQ-036 redirect=1, redirect_pc=0x40 together with stall=1: next cycle imem_addr=0x40, ifid_valid=0; following cycle ifid_pc=0x40, ifid_valid=1.
REQ-037 HALT_WORD at address 3: ifid_pc=3 valid once, then halted=1, ifid_valid=0, imem_addr stays 3; redirect to 0x10 clears halted and fetches 0x10.
REQ-038 rst asserted during stall in HALTED: next cycle state IDLE, imem_addr=RESET_PC, all ifid_* zero, halted=0.
